imu_avg: RTL and testbench
==========================

# imu_avg

Moving-average smoother that sits directly downstream of the IMU SPI reader and consumes its 96-bit `data_t` sample register. It detects each newly published sample, keeps a DEPTH-deep history, and maintains one running sum per field (pitch, roll, yaw, x, y, z). Each update publishes a signed, averaged `data_t` with a one-cycle valid strobe for the tilt and display logic.

## Interface
- `DEPTH`, default 8: window length in samples; must be a power of two and at least 2.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `in_data`  in  96 (`data_t`): raw sample from the IMU reader. Fields are signed two's complement.
- `avg_data`  out  96 (`data_t`): averaged sample, one signed 16-bit value per field.
- `avg_valid`  out  1: one-cycle pulse when `avg_data` updates with a full window.
- `fill`  out  $clog2(DEPTH)+1: number of samples in the window; saturates at DEPTH.
- `busy`  out  1: high while a sample is being processed.

## Operation
- New-sample detection:
  - Registers `last_in` (reset 0) and `sample` hold the last accepted input.
  - In IDLE, `in_data != last_in` means a new sample. The block copies `in_data` into both registers and enters ACCUM.
  - Identical consecutive samples are not detected. This is accepted behaviour, because the reader only changes `in_data` when new data arrives.
- States:
  - IDLE: wait for a new sample as above.
  - ACCUM: `k` = 0..5, one field per cycle, order pitch, roll, yaw, x, y, z.
    - `sum[k] <= sum[k] + sext(sample[k]) - (fill==DEPTH ? sext(hist[wr_ptr][k]) : 0)`.
  - COMMIT:
    - Write `hist[wr_ptr] <= sample`.
    - Increment `wr_ptr`, wrapping from DEPTH-1 to 0.
    - Increment `fill`, saturating at DEPTH.
  - PUBLISH:
    - `avg_data[k] <= sum[k] >>> $clog2(DEPTH)`, an arithmetic shift that truncates toward negative infinity.
    - Assert `avg_valid` only if `fill==DEPTH`.
    - Return to IDLE.
- Width rules:
  - Each sum is 16+$clog2(DEPTH) bits signed, sign-extended on every add. It cannot overflow.
  - The shifted result always fits in 16 bits.
- Samples arriving while busy are not queued. On return to IDLE, the current `in_data` is compared against `last_in`. Intermediate values are lost; the newest value is taken.
- While `fill<DEPTH`:
  - `avg_data` still updates, but the divisor stays DEPTH, so the output is biased toward 0.
  - `avg_valid` stays low.
- `busy` is high in ACCUM, COMMIT and PUBLISH.

## Timing
- Reset value of every output and internal register is 0. This covers `avg_data`, `avg_valid`, `fill`, `busy`, sums, `wr_ptr`, `last_in`, the history contents, and the state (IDLE).
- Because `last_in` resets to 0 and the reader's output also resets to 0, there is no spurious sample after reset.
- Latency: if a change is seen in IDLE at cycle T:
  - ACCUM occupies cycles T+1..T+6.
  - COMMIT is cycle T+7.
  - PUBLISH is cycle T+8.
  - `avg_data` and `avg_valid` are visible from cycle T+9. `avg_valid` is high for exactly that one cycle.
- Throughput: one sample per 9 cycles. The earliest next detection is cycle T+9. The reader publishes roughly every 4M cycles, so there is large slack.
- `avg_data` holds its value between updates.
- Reset mid-operation: processing aborts, all state clears, and no `avg_valid` is issued.

## Structure
- Move `data_t` into a shared package `imu_pkg`, together with `IMU_FIELDS = 6`. `imu_multi` and this block both import it.
- Field access is by index (`[k*16 +: 16]`) over the packed struct.
- Sub-module `imu_hist_ram`:
  - DEPTH×96 storage with synchronous write and combinational read at `wr_ptr`, giving the oldest entry when full.
  - Read-before-write within COMMIT is guaranteed by the ACCUM/COMMIT ordering.

## Test plan
- Reset, then hold `in_data`=0 for 100 cycles → `busy`=0, `avg_valid` never asserts, `fill`=0.
- DEPTH=8; apply eight distinct samples, each with x=+800, other fields 1..8 → `avg_valid` is first seen 9 cycles after the 8th change. At that point `avg_data.x`=800 and `fill`=8. No `avg_valid` occurs for samples 1–7.
- Full window, all x=+800, then one sample with x=-800 → `avg_data.x`=600, since (7·800−800)/8.
- Negative rounding check: sums giving −1/8 (seven 0s and one −1) → `avg_data` field = −1 (0xFFFF), not 0.
- Change `in_data` twice during `busy` (A then B) → only B is processed after return to IDLE; `fill` increments by exactly 1 for the pair.
- Assert `reset` during ACCUM of sample 9 → next cycle all outputs are 0 and there is no `avg_valid` pulse. A fresh 8-sample fill is required before `avg_valid` asserts again.

Source files
------------

// File: rtl/imu_pkg.sv
// Shared IMU types: the 96-bit sample record used by the SPI reader and its consumers.
// Field k lives at bits [k*16 +: 16], so pitch is the least significant field.
package imu_pkg;

  localparam int IMU_FIELDS = 6;
  localparam int FIELD_W    = 16;

  // Declared MSB-first so that index 0 (pitch) sits in the low 16 bits
  typedef struct packed {
    logic signed [FIELD_W-1:0] z;
    logic signed [FIELD_W-1:0] y;
    logic signed [FIELD_W-1:0] x;
    logic signed [FIELD_W-1:0] yaw;
    logic signed [FIELD_W-1:0] roll;
    logic signed [FIELD_W-1:0] pitch;
  } data_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_COMMIT,
    ST_PUBLISH
  } avgState_t;

  function automatic logic signed [FIELD_W-1:0] getField(input data_t d, input logic [2:0] k);
    return d[k*FIELD_W +: FIELD_W];
  endfunction

endpackage

// File: rtl/imu_avg_if.sv
// Bundle between the IMU reader side (master) and the moving-average smoother (slave).
interface imu_avg_if #(
  parameter int DEPTH = 8
);
  import imu_pkg::*;

  data_t                  in_data;
  data_t                  avg_data;
  logic                   avg_valid;
  logic [$clog2(DEPTH):0] fill;
  logic                   busy;

  modport master (
    output in_data,
    input  avg_data,
    input  avg_valid,
    input  fill,
    input  busy
  );

  modport slave (
    input  in_data,
    output avg_data,
    output avg_valid,
    output fill,
    output busy
  );

endinterface

// File: rtl/imu_hist_ram.sv
// DEPTH-entry sample history. Reading at the write pointer yields the oldest entry once full,
// so the smoother can subtract it before COMMIT overwrites it.
module imu_hist_ram
  import imu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  data_t                    i_wdata,
  output data_t                    o_rdata
);

  data_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/imu_avg.sv
// Moving-average smoother: one running sum per IMU field, updated one field per cycle,
// publishing sum/DEPTH (floor) with a one-cycle valid once the window is full.
module imu_avg
  import imu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  imu_avg_if.slave bus
);

  localparam int                PTR_W     = $clog2(DEPTH);
  localparam int                FILL_W    = PTR_W + 1;
  localparam int                SUM_W     = FIELD_W + PTR_W;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [2:0]        K_LAST    = 3'(IMU_FIELDS - 1);

  avgState_t                r_state;
  data_t                    r_lastIn;
  data_t                    r_sample;
  data_t                    r_avgData;
  logic                     r_avgValid;
  logic                     r_busy;
  logic [2:0]               r_k;
  logic [PTR_W-1:0]         r_wrPtr;
  logic [FILL_W-1:0]        r_fill;
  logic signed [SUM_W-1:0]  r_sum [IMU_FIELDS];

  data_t                    w_histRd;
  data_t                    w_avgNext;
  logic                     w_histWe;
  logic                     w_full;
  logic signed [SUM_W-1:0]  w_addNew;
  logic signed [SUM_W-1:0]  w_subOld;
  logic signed [SUM_W-1:0]  w_sumNext;

  imu_hist_ram #(
    .DEPTH (DEPTH)
  ) uHist (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_histWe),
    .i_addr  (r_wrPtr),
    .i_wdata (r_sample),
    .o_rdata (w_histRd)
  );

  assign w_full   = (r_fill == FILL_FULL);
  assign w_histWe = (r_state == ST_COMMIT);

  // Both terms are sign-extended to the sum width, so the running sum can never overflow
  assign w_addNew  = SUM_W'(getField(r_sample, r_k));
  assign w_subOld  = w_full ? SUM_W'(getField(w_histRd, r_k)) : '0;
  assign w_sumNext = r_sum[r_k] + w_addNew - w_subOld;

  // Arithmetic shift floors toward negative infinity; the result always fits in a field
  always_comb begin
    w_avgNext = '0;
    for (int k = 0; k < IMU_FIELDS; k++) begin
      w_avgNext[k*FIELD_W +: FIELD_W] = FIELD_W'(r_sum[k] >>> PTR_W);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_lastIn   <= '0;
      r_sample   <= '0;
      r_avgData  <= '0;
      r_avgValid <= 1'b0;
      r_busy     <= 1'b0;
      r_k        <= '0;
      r_wrPtr    <= '0;
      r_fill     <= '0;
      for (int k = 0; k < IMU_FIELDS; k++) begin
        r_sum[k] <= '0;
      end
    end else begin
      r_avgValid <= 1'b0;
      case (r_state)
        // Changes arriving while busy are dropped; only the value present on return is compared
        ST_IDLE: begin
          if (bus.in_data != r_lastIn) begin
            r_lastIn <= bus.in_data;
            r_sample <= bus.in_data;
            r_k      <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_sum[r_k] <= w_sumNext;
          if (r_k == K_LAST) begin
            r_state <= ST_COMMIT;
          end else begin
            r_k <= r_k + 3'd1;
          end
        end
        ST_COMMIT: begin
          r_wrPtr <= (r_wrPtr == PTR_LAST) ? '0 : r_wrPtr + PTR_W'(1);
          if (!w_full) begin
            r_fill <= r_fill + FILL_W'(1);
          end
          r_state <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          r_avgData  <= w_avgNext;
          r_avgValid <= w_full;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.avg_data  = r_avgData;
  assign bus.avg_valid = r_avgValid;
  assign bus.fill      = r_fill;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_imu_avg.sv
// Bench for imu_avg: table of hand-computed vectors plus a window-sum scoreboard checked
// on every publish, with hand sequences for mid-busy changes and reset during ACCUM.
module tb_imu_avg;
  import imu_pkg::*;

  localparam int DEPTH = 8;
  localparam int NROWS = 17;

  typedef struct {
    data_t avg;
    logic  valid;
    int    fill;
  } exp_t;

  typedef struct {
    data_t sample;
    int    expPitch;
    int    expX;
    int    expFill;
    logic  expValid;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset;
  int    checks = 0;
  int    failures = 0;
  int    pubCount = 0;
  exp_t  sbQ[$];
  data_t mdlWin[$];
  vec_t  vecs[NROWS];
  bit    prevBusy;

  always #5 clk = ~clk;

  imu_avg_if #(.DEPTH(DEPTH)) bus ();

  imu_avg #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic data_t mk(input int p, input int r, input int yw, input int x, input int y, input int z);
    data_t d;
    d.pitch = 16'(p);
    d.roll  = 16'(r);
    d.yaw   = 16'(yw);
    d.x     = 16'(x);
    d.y     = 16'(y);
    d.z     = 16'(z);
    return d;
  endfunction

  function automatic data_t mkF(input int i);
    return mk(-3 * i, 7 * i - 20, 1000 - i, -1200 + 50 * i, i, -i);
  endfunction

  function automatic vec_t mkVec(input data_t s, input int p, input int x, input int f, input logic v);
    vec_t t;
    t.sample   = s;
    t.expPitch = p;
    t.expX     = x;
    t.expFill  = f;
    t.expValid = v;
    return t;
  endfunction

  function automatic int floorDiv(input int a, input int b);
    if (a < 0 && (a % b) != 0) return a / b - 1;
    return a / b;
  endfunction

  // Reference: recompute each field from the whole window, divide by DEPTH rounding down
  task automatic modelPush(input data_t s);
    exp_t e;
    int   sum;
    mdlWin.push_back(s);
    if (mdlWin.size() > DEPTH) void'(mdlWin.pop_front());
    e.avg = '0;
    for (int k = 0; k < IMU_FIELDS; k++) begin
      sum = 0;
      foreach (mdlWin[j]) sum += int'(getField(mdlWin[j], 3'(k)));
      e.avg[k*16 +: 16] = 16'(floorDiv(sum, DEPTH));
    end
    e.valid = (mdlWin.size() == DEPTH);
    e.fill  = mdlWin.size();
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input data_t s, output int lat);
    bit seen;
    bit done;
    seen = 0;
    done = 0;
    lat  = 0;
    @(negedge clk);
    bus.in_data = s;
    modelPush(s);
    while (lat < 50 && !done) begin
      @(negedge clk);
      lat++;
      if (bus.busy) seen = 1;
      else if (seen) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL stim_timeout actual=%0d cycles required=publish", lat);
    end
  endtask

  // Publish monitor: a busy falling edge outside reset is one processed sample
  initial begin : monitor
    exp_t e;
    prevBusy = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        prevBusy = 0;
      end else begin
        if (prevBusy && !bus.busy) begin
          pubCount++;
          if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_empty actual=publish required=none");
          end else begin
            e = sbQ.pop_front();
            checkOutput("sb_avg", bus.avg_data, e.avg);
            checkOutput("sb_valid", bus.avg_valid, e.valid);
            checkOutput("sb_fill", bus.fill, e.fill);
          end
        end else begin
          checkOutput("no_valid", bus.avg_valid, 1'b0);
        end
        prevBusy = bus.busy;
      end
    end
  end

  initial begin : mainTest
    int lat;
    int base;
    int n;

    vecs[0]  = mkVec(mk(1, 1, 1, 800, 1, 1),    0,  100, 1, 1'b0);
    vecs[1]  = mkVec(mk(2, 2, 2, 800, 2, 2),    0,  200, 2, 1'b0);
    vecs[2]  = mkVec(mk(3, 3, 3, 800, 3, 3),    0,  300, 3, 1'b0);
    vecs[3]  = mkVec(mk(4, 4, 4, 800, 4, 4),    1,  400, 4, 1'b0);
    vecs[4]  = mkVec(mk(5, 5, 5, 800, 5, 5),    1,  500, 5, 1'b0);
    vecs[5]  = mkVec(mk(6, 6, 6, 800, 6, 6),    2,  600, 6, 1'b0);
    vecs[6]  = mkVec(mk(7, 7, 7, 800, 7, 7),    3,  700, 7, 1'b0);
    vecs[7]  = mkVec(mk(8, 8, 8, 800, 8, 8),    4,  800, 8, 1'b1);
    vecs[8]  = mkVec(mk(9, 9, 9, -800, 9, 9),   5,  600, 8, 1'b1);
    vecs[9]  = mkVec(mk(0, 0, 10, 0, 0, 0),     5,  500, 8, 1'b1);
    vecs[10] = mkVec(mk(0, 0, 11, 0, 0, 0),     4,  400, 8, 1'b1);
    vecs[11] = mkVec(mk(0, 0, 12, 0, 0, 0),     4,  300, 8, 1'b1);
    vecs[12] = mkVec(mk(0, 0, 13, 0, 0, 0),     3,  200, 8, 1'b1);
    vecs[13] = mkVec(mk(0, 0, 14, 0, 0, 0),     3,  100, 8, 1'b1);
    vecs[14] = mkVec(mk(0, 0, 15, 0, 0, 0),     2,    0, 8, 1'b1);
    vecs[15] = mkVec(mk(0, 0, 16, 0, 0, 0),     1, -100, 8, 1'b1);
    vecs[16] = mkVec(mk(-1, 0, 17, 0, 0, 0),   -1,    0, 8, 1'b1);

    reset = 1'b1;
    bus.in_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_avg", bus.avg_data, '0);
    checkOutput("rst_valid", bus.avg_valid, 1'b0);
    checkOutput("rst_fill", bus.fill, 0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;

    repeat (100) @(negedge clk);
    checkOutput("idle_busy", bus.busy, 1'b0);
    checkOutput("idle_fill", bus.fill, 0);
    checkOutput("idle_pubs", pubCount, 0);

    for (int i = 0; i < NROWS; i++) begin
      applyStimulus(vecs[i].sample, lat);
      checkOutput($sformatf("row%0d_latency", i + 1), lat, 9);
      checkOutput($sformatf("row%0d_pitch", i + 1), bus.avg_data.pitch, 16'(vecs[i].expPitch));
      checkOutput($sformatf("row%0d_x", i + 1), bus.avg_data.x, 16'(vecs[i].expX));
      checkOutput($sformatf("row%0d_fill", i + 1), bus.fill, vecs[i].expFill);
      checkOutput($sformatf("row%0d_valid", i + 1), bus.avg_valid, vecs[i].expValid);
    end

    // Reset lands while the DUT is mid-ACCUM on a ninth-plus sample
    @(negedge clk);
    bus.in_data = mk(5, 5, 5, 5, 5, 5);
    repeat (3) @(negedge clk);
    checkOutput("prerst_busy", bus.busy, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    bus.in_data = '0;
    mdlWin.delete();
    sbQ.delete();
    @(negedge clk);
    checkOutput("midrst_avg", bus.avg_data, '0);
    checkOutput("midrst_valid", bus.avg_valid, 1'b0);
    checkOutput("midrst_fill", bus.fill, 0);
    checkOutput("midrst_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("postrst_busy", bus.busy, 1'b0);
    checkOutput("postrst_fill", bus.fill, 0);

    for (int i = 1; i <= 3; i++) begin
      applyStimulus(mkF(i), lat);
      checkOutput($sformatf("refill%0d_fill", i), bus.fill, i);
    end

    // Sample 4 in flight, then A and B while busy: only B should follow
    base = pubCount;
    @(negedge clk);
    bus.in_data = mkF(4);
    modelPush(mkF(4));
    repeat (3) @(negedge clk);
    bus.in_data = mk(111, 222, 333, 444, 555, 666);
    repeat (2) @(negedge clk);
    bus.in_data = mkF(5);
    modelPush(mkF(5));
    n = 0;
    while (pubCount < base + 2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ab_publishes", pubCount, base + 2);
    checkOutput("ab_fill", bus.fill, 5);
    checkOutput("ab_sb_drained", sbQ.size(), 0);

    for (int i = 6; i <= 8; i++) begin
      applyStimulus(mkF(i), lat);
      checkOutput($sformatf("refill%0d_fill", i), bus.fill, i);
      checkOutput($sformatf("refill%0d_valid", i), bus.avg_valid, (i == 8) ? 1'b1 : 1'b0);
    end

    repeat (5) @(negedge clk);
    checkOutput("end_sb_drained", sbQ.size(), 0);
    checkOutput("end_busy", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
